// File: rtl/shooter_controller.sv
// rtl/shooter_controller.sv - shooter position integrator and rate-limited fire requester
// Optional SHOOTER_FIRE_EDGE_EN: require fire key release between shots.
module shooter_controller #(
  parameter logic [9:0]  X_START         = 10'd320,
  parameter logic [9:0]  Y_START         = 10'd400,
  parameter logic [9:0]  STEP            = 10'd2,
  parameter logic [9:0]  X_MIN           = 10'd16,
  parameter logic [9:0]  X_MAX           = 10'd623,
  parameter logic [9:0]  Y_MIN           = 10'd16,
  parameter logic [9:0]  Y_MAX           = 10'd463,
  parameter int unsigned COOLDOWN_FRAMES = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [2:0] ShooterMove,
  input  logic       is_shot,
  input  logic       fire_ack,
  output logic [9:0] shooter_x,
  output logic [9:0] shooter_y,
  output logic       fire_req,
  output logic [9:0] fire_x,
  output logic [9:0] fire_y
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    COOL = 2'd2
  } state_t;

  localparam logic [2:0] MOVE_UP    = 3'b001;
  localparam logic [2:0] MOVE_RIGHT = 3'b010;
  localparam logic [2:0] MOVE_DOWN  = 3'b011;
  localparam logic [2:0] MOVE_LEFT  = 3'b100;
  localparam logic [7:0] COOL_LOAD  = 8'(COOLDOWN_FRAMES);

  state_t     state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       fire_req_q, fire_req_d;
  logic [9:0] fire_x_q, fire_x_d;
  logic [9:0] fire_y_q, fire_y_d;
  logic [7:0] cnt_q, cnt_d;
  logic       fire_ok;

`ifdef SHOOTER_FIRE_EDGE_EN
  logic armed_q, armed_d;

  assign fire_ok = is_shot & armed_q;

  always_comb begin
    armed_d = armed_q;
    if (frame_tick && !is_shot) begin
      armed_d = 1'b1;
    end
    if (state_q == IDLE && frame_tick && fire_ok) begin
      armed_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      armed_q <= 1'b1;
    end else begin
      armed_q <= armed_d;
    end
  end
`else
  assign fire_ok = is_shot;
`endif

  // Clamp comparisons happen before the add/subtract so 10-bit values never wrap.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (frame_tick) begin
      case (ShooterMove)
        MOVE_UP:    y_d = (y_q < Y_MIN + STEP) ? Y_MIN : y_q - STEP;
        MOVE_DOWN:  y_d = (y_q > Y_MAX - STEP) ? Y_MAX : y_q + STEP;
        MOVE_LEFT:  x_d = (x_q < X_MIN + STEP) ? X_MIN : x_q - STEP;
        MOVE_RIGHT: x_d = (x_q > X_MAX - STEP) ? X_MAX : x_q + STEP;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    fire_req_d = fire_req_q;
    fire_x_d   = fire_x_q;
    fire_y_d   = fire_y_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (frame_tick && fire_ok) begin
          state_d    = REQ;
          fire_req_d = 1'b1;
          fire_x_d   = x_q;
          fire_y_d   = y_q - 10'd8;
        end
      end
      REQ: begin
        if (fire_ack) begin
          fire_req_d = 1'b0;
          if (COOLDOWN_FRAMES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = COOL;
            cnt_d   = COOL_LOAD;
          end
        end
      end
      COOL: begin
        if (frame_tick) begin
          if (cnt_q <= 8'd1) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        fire_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      x_q        <= X_START;
      y_q        <= Y_START;
      fire_req_q <= 1'b0;
      fire_x_q   <= 10'd0;
      fire_y_q   <= 10'd0;
      cnt_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      fire_req_q <= fire_req_d;
      fire_x_q   <= fire_x_d;
      fire_y_q   <= fire_y_d;
      cnt_q      <= cnt_d;
    end
  end

  assign shooter_x = x_q;
  assign shooter_y = y_q;
  assign fire_req  = fire_req_q;
  assign fire_x    = fire_x_q;
  assign fire_y    = fire_y_q;

endmodule
